lru_stack_array: RTL and testbench
==================================

Name: lru_stack_array

Overview:
- Per-set 4-entry recency stack for the 4-way cache's LRU replacement policy.
- Stores one ordered list of 2-bit way IDs per set: position 0 is MRU, position 3 is LRU.
- On a cache access it moves the used way to MRU, using the same hit-position/shift rule the lru_mux_logic select encoding expresses.
- Sits between the cache controller (access/update source) and the way-replacement path, which consumes lru_way.

Parameters:
- SET_BITS, 3, log2 of number of sets; NUM_SETS = 2**SET_BITS.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- lookup_set  input  SET_BITS  set index for the replacement query
- lru_way  output  2  way at position 3 of stack[lookup_set]
- mru_way  output  2  way at position 0 of stack[lookup_set]
- update_en  input  1  single-cycle strobe; record an access this cycle
- update_set  input  SET_BITS  set index being accessed
- used_way  input  2  way that was hit or filled
- flush  input  1  synchronous re-initialise of all stacks
- update_done  output  1  registered pulse, high the cycle after an accepted update or flush

Behaviour:
- State: NUM_SETS x 4 x 2-bit entries, stack[s][p].
- Reset (rst=1, asynchronous):
  - stack[s][p] = p for every s, i.e. {0,1,2,3}.
  - update_done = 0.
  - Therefore lru_way = 3 and mru_way = 0 for any lookup_set while in reset.
- lru_way and mru_way are combinational reads of the registered state. There is no read latency.
- Hit position k = lowest p with stack[update_set][p] == used_way.
  - The stack is always a permutation, so exactly one match exists.
  - If no match is found (corruption only), k = 0. This is the same priority and default as the mux-select logic.
- Update on a rising edge with update_en=1 and flush=0:
  - new[0] = used_way.
  - new[p] = old[p-1] for 1 <= p <= k.
  - new[p] = old[p] for p > k.
  - k=0 leaves the stack unchanged.
  - Only set update_set changes; all other sets hold.
- Flush on a rising edge with flush=1:
  - All sets return to {0,1,2,3} in one cycle.
  - Flush has priority over a simultaneous update_en, which is dropped.
- update_done is registered: it equals (update_en | flush) of the previous cycle.
- Simultaneous lookup and update of the same set: in that cycle lru_way/mru_way show the pre-update ordering. The new ordering is visible the following cycle.
- Back-to-back updates to the same set on consecutive cycles are legal. Each one operates on the result of the previous one.
- Invariant: every set always holds a permutation of {0,1,2,3}. Verification asserts this every cycle.
- Reset asserted mid-operation overrides any in-flight update immediately. State returns to the reset values with no clock required.
- No X propagation: used_way/update_set are ignored when update_en=0.

Test Plan:
- Reset, then sweep lookup_set 0..7 -> lru_way=3, mru_way=0 for every set; update_done=0.
- Set 2: update used_way=2 (k=2) -> stack[2]={2,0,1,3}. Then used_way=3 (k=3) -> {3,2,0,1}, lru_way=1. Set 5 still reads lru_way=3.
- Set 0: update used_way=0 (k=0) -> stack unchanged {0,1,2,3}; update_done pulses 1 cycle later.
- Set 1: back-to-back updates with used_way 3,2,1,0 on consecutive cycles -> {0,1,2,3}; lru_way=3. During the first edge's cycle lookup_set=1 reads lru_way=3 (pre-update).
- Set 4 modified to {3,2,0,1}, then flush=1 with update_en=1, update_set=4, used_way=1 -> all sets {0,1,2,3} next cycle; the update is not applied.
- Randomised 10k updates plus asynchronous rst pulse mid-stream -> permutation invariant never violated; after rst all sets read lru_way=3 before the next clock edge.

Source files
------------

// File: rtl/lru_stack_array.sv
// Per-set 4-entry recency stack for a 4-way cache.
// Position 0 holds the MRU way and position 3 holds the LRU way; an access moves the used way to MRU.
module lru_stack_array #(
    parameter int unsigned SET_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SET_BITS-1:0] lookup_set,
    output logic [1:0]          lru_way,
    output logic [1:0]          mru_way,
    input  logic                update_en,
    input  logic [SET_BITS-1:0] update_set,
    input  logic [1:0]          used_way,
    input  logic                flush,
    output logic                update_done
);

    localparam int unsigned NUM_SETS = 1 << SET_BITS;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned WAY_W    = 2;
    localparam int unsigned POS_W    = 2;

    logic [WAY_W-1:0] r_stack [NUM_SETS][DEPTH];
    logic             r_update_done;

    logic [WAY_W-1:0] w_old [DEPTH];
    logic [WAY_W-1:0] w_new [DEPTH];
    logic [POS_W-1:0] w_hit_pos;

    // Hit position: lowest matching slot, defaulting to 0 when nothing matches.
    always_comb begin
        w_hit_pos = '0;
        for (int p = 0; p < DEPTH; p++) begin
            w_old[p] = r_stack[update_set][p];
        end
        for (int p = DEPTH - 1; p >= 0; p--) begin
            if (w_old[p] == used_way) begin
                w_hit_pos = POS_W'(p);
            end
        end
    end

    // Slots above the hit shift down by one; the used way lands at MRU.
    always_comb begin
        for (int p = 0; p < DEPTH; p++) begin
            w_new[p] = w_old[p];
        end
        w_new[0] = used_way;
        for (int p = 1; p < DEPTH; p++) begin
            if (POS_W'(p) <= w_hit_pos) begin
                w_new[p] = w_old[p-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int p = 0; p < DEPTH; p++) begin
                    r_stack[s][p] <= WAY_W'(p);
                end
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int p = 0; p < DEPTH; p++) begin
                    r_stack[s][p] <= WAY_W'(p);
                end
            end
        end else if (update_en) begin
            for (int p = 0; p < DEPTH; p++) begin
                r_stack[update_set][p] <= w_new[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_update_done <= 1'b0;
        end else begin
            r_update_done <= update_en | flush;
        end
    end

    // Lookups read the registered state directly, so a same-cycle update is not yet visible.
    assign lru_way     = r_stack[lookup_set][DEPTH-1];
    assign mru_way     = r_stack[lookup_set][0];
    assign update_done = r_update_done;

endmodule

// File: tb/tb_lru_stack_array.sv
// Bench for lru_stack_array: directed scenarios plus random traffic checked against a queue-based recency model.
`timescale 1ns/10ps
module tb_lru_stack_array;

    localparam int unsigned SET_BITS = 3;
    localparam int unsigned NUM_SETS = 1 << SET_BITS;

    logic                clk = 1'b0;
    logic                rst;
    logic [SET_BITS-1:0] lookup_set;
    logic [1:0]          lru_way;
    logic [1:0]          mru_way;
    logic                update_en;
    logic [SET_BITS-1:0] update_set;
    logic [1:0]          used_way;
    logic                flush;
    logic                update_done;

    int errors = 0;
    int checks = 0;

    // Model: per set, a queue ordered most-recent first.
    logic [1:0] mdl [NUM_SETS][$];

    lru_stack_array #(.SET_BITS(SET_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .lookup_set (lookup_set),
        .lru_way    (lru_way),
        .mru_way    (mru_way),
        .update_en  (update_en),
        .update_set (update_set),
        .used_way   (used_way),
        .flush      (flush),
        .update_done(update_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mdl_init();
        for (int s = 0; s < NUM_SETS; s++) begin
            mdl[s] = {2'd0, 2'd1, 2'd2, 2'd3};
        end
    endtask

    task automatic mdl_touch(input int s, input logic [1:0] w);
        for (int i = 0; i < mdl[s].size(); i++) begin
            if (mdl[s][i] == w) begin
                mdl[s].delete(i);
                break;
            end
        end
        mdl[s].push_front(w);
    endtask

    // Every stack must hold each way exactly once.
    task automatic chk_perm();
        logic [3:0] seen;
        for (int s = 0; s < NUM_SETS; s++) begin
            seen = '0;
            for (int p = 0; p < 4; p++) begin
                seen[dut.r_stack[s][p]] = 1'b1;
            end
            chk($sformatf("perm_set%0d", s), seen, 4'hf);
        end
    endtask

    // One clock: drive at negedge, check pre-update lookup, advance model at posedge, check done.
    task automatic cycle(input logic en, input int s, input logic [1:0] w,
                         input logic fl, input int lk);
        logic exp_done;
        update_en  = en;
        update_set = SET_BITS'(s);
        used_way   = w;
        flush      = fl;
        lookup_set = SET_BITS'(lk);
        #1;
        chk("lru_pre", {2'b0, lru_way}, {2'b0, mdl[lk][3]});
        chk("mru_pre", {2'b0, mru_way}, {2'b0, mdl[lk][0]});
        @(posedge clk);
        exp_done = en | fl;
        if (fl) mdl_init();
        else if (en) mdl_touch(s, w);
        @(negedge clk);
        chk("done", {3'b0, update_done}, {3'b0, exp_done});
        chk_perm();
    endtask

    task automatic idle();
        update_en = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic look(input string tag, input int lk, input logic [1:0] exp_lru,
                        input logic [1:0] exp_mru);
        lookup_set = SET_BITS'(lk);
        #1;
        chk({tag, "_lru"}, {2'b0, lru_way}, {2'b0, exp_lru});
        chk({tag, "_mru"}, {2'b0, mru_way}, {2'b0, exp_mru});
    endtask

    initial begin
        rst        = 1'b1;
        update_en  = 1'b0;
        update_set = '0;
        used_way   = '0;
        flush      = 1'b0;
        lookup_set = '0;
        mdl_init();
        #2;
        for (int s = 0; s < NUM_SETS; s++) begin
            look("rst_sweep", s, 2'd3, 2'd0);
        end
        chk("rst_done", {3'b0, update_done}, 4'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Set 2: k=2 then k=3.
        cycle(1'b1, 2, 2'd2, 1'b0, 2);
        cycle(1'b1, 2, 2'd3, 1'b0, 2);
        idle();
        look("s2", 2, 2'd1, 2'd3);
        chk("s2_pos1", {2'b0, dut.r_stack[2][1]}, 4'd2);
        chk("s2_pos2", {2'b0, dut.r_stack[2][2]}, 4'd0);
        look("s5", 5, 2'd3, 2'd0);

        // Set 0: k=0 leaves the stack alone but still pulses done.
        cycle(1'b1, 0, 2'd0, 1'b0, 0);
        cycle(1'b0, 0, 2'd0, 1'b0, 0);
        look("s0", 0, 2'd3, 2'd0);

        // Set 1: back-to-back 3,2,1,0; first edge's cycle reads the old order.
        update_en = 1'b1; update_set = 3'd1; used_way = 2'd3; lookup_set = 3'd1;
        #1;
        chk("s1_pre_edge_lru", {2'b0, lru_way}, 4'd3);
        cycle(1'b1, 1, 2'd3, 1'b0, 1);
        cycle(1'b1, 1, 2'd2, 1'b0, 1);
        cycle(1'b1, 1, 2'd1, 1'b0, 1);
        cycle(1'b1, 1, 2'd0, 1'b0, 1);
        idle();
        look("s1", 1, 2'd3, 2'd0);

        // Set 4 to {3,2,0,1}, then flush wins over a simultaneous update.
        cycle(1'b1, 4, 2'd2, 1'b0, 4);
        cycle(1'b1, 4, 2'd3, 1'b0, 4);
        idle();
        look("s4_mod", 4, 2'd1, 2'd3);
        cycle(1'b1, 4, 2'd1, 1'b1, 4);
        idle();
        for (int s = 0; s < NUM_SETS; s++) begin
            look("flush_sweep", s, 2'd3, 2'd0);
        end

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                idle();
                @(posedge clk);
                #2;
                rst = 1'b1;
                mdl_init();
                for (int s = 0; s < NUM_SETS; s++) begin
                    lookup_set = SET_BITS'(s);
                    #0.5;
                    chk("async_rst_lru", {2'b0, lru_way}, 4'd3);
                    chk("async_rst_mru", {2'b0, mru_way}, 4'd0);
                end
                chk("async_rst_done", {3'b0, update_done}, 4'd0);
                @(negedge clk);
                rst = 1'b0;
            end
            begin
                int s;
                int lk;
                s  = int'($urandom_range(NUM_SETS - 1, 0));
                lk = ($urandom_range(3, 0) == 0) ? s : int'($urandom_range(NUM_SETS - 1, 0));
                cycle($urandom_range(3, 0) != 0, s, 2'($urandom_range(3, 0)),
                      $urandom_range(127, 0) == 0, lk);
            end
        end
        idle();
        for (int s = 0; s < NUM_SETS; s++) begin
            look("final", s, mdl[s][3], mdl[s][0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
